// File: rtl/bus_uart_tx_if.sv
// Slave-side view of the CPU data bus for the UART transmitter window.
// rData is combinational from the slave for the MCU read-data mux.
interface bus_uart_tx_if;
  logic        sel;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wData;
  logic [31:0] rData;

  modport master (output sel, output we, output addr, output wData, input rData);
  modport slave  (input sel, input we, input addr, input wData, output rData);
endinterface

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus stores fill a byte FIFO that a
// baud-timed shifter drains LSB first. Status/config read back combinationally.
module bus_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DEFAULT_DIV = 867
) (
  input  logic           clk,
  input  logic           reset,
  bus_uart_tx_if.slave   bus,
  output logic           tx,
  output logic           irq_empty
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            enable_q, enable_d;
  logic [15:0]     baud_div_q, baud_div_d;

  logic [1:0]      state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     div_q, div_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            irq_empty_q, irq_empty_d;

  logic [1:0]      reg_sel;
  logic            wr_en, push, push_ok, pop;
  logic            full, empty, busy, start_ok, cnt_done;
  logic [2:0]      idx_next;
  logic [31:0]     status;

  logic unused_bus;
  assign unused_bus = ^{bus.wData[31:16], bus.addr[1:0]};

  assign reg_sel  = bus.addr[3:2];
  assign wr_en    = bus.sel & bus.we;
  assign push     = wr_en & (reg_sel == 2'd0);
  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign busy     = (state_q != StIdle);
  // A push into a full FIFO still lands when the shifter pops on the same edge.
  assign push_ok  = push & (~full | pop);
  assign start_ok = enable_q & ~empty;
  assign cnt_done = (cnt_q == div_q);
  assign idx_next = idx_q + 3'd1;

  // FIFO and register file
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    enable_d   = enable_q;
    baud_div_d = baud_div_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = bus.wData[7:0];
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (wr_en && reg_sel == 2'd2) baud_div_d = bus.wData[15:0];
    if (wr_en && reg_sel == 2'd3) begin
      enable_d = bus.wData[0];
      if (bus.wData[1]) overflow_d = 1'b0;
    end
    if (push && full && !pop) overflow_d = 1'b1;
  end

  // Transmit FSM; tx is registered so it changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (start_ok) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          div_d   = baud_div_q;
          cnt_d   = '0;
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (cnt_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StData;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StData: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_next;
            tx_d  = shift_q[idx_next];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (start_ok) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            div_d   = baud_div_q;
            state_d = StStart;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    irq_empty_d = (count_d == '0) & (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      enable_q    <= 1'b1;
      baud_div_q  <= 16'(DEFAULT_DIV);
      state_q     <= StIdle;
      cnt_q       <= '0;
      div_q       <= 16'(DEFAULT_DIV);
      idx_q       <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      irq_empty_q <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      enable_q    <= enable_d;
      baud_div_q  <= baud_div_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      irq_empty_q <= irq_empty_d;
    end
  end

  assign status = {16'd0, 8'(count_q), 4'd0, overflow_q, busy, empty, full};

  always_comb begin
    bus.rData = '0;
    if (bus.sel) begin
      case (reg_sel)
        2'd1:    bus.rData = status;
        2'd2:    bus.rData = {16'd0, baud_div_q};
        2'd3:    bus.rData = {31'd0, enable_q};
        default: bus.rData = '0;
      endcase
    end
  end

  assign tx        = tx_q;
  assign irq_empty = irq_empty_q;

endmodule
